// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the game sequencer.
//   state_t       - sequencer state encoding (also the value of the 'state' output)
//   OBJ_W_DEF     - default object bounding box width in pixels
//   OBJ_H_DEF     - default object bounding box height in pixels
//   GROUND_Y_DEF  - default object Y at or beyond which the object is missed
package game_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        PLAY  = 3'b001,
        HIT   = 3'b010,
        OVER  = 3'b011,
        PAUSE = 3'b100
    } state_t;

    localparam int unsigned OBJ_W_DEF    = 32;
    localparam int unsigned OBJ_H_DEF    = 32;
    localparam int unsigned GROUND_Y_DEF = 448;

endpackage

// File: rtl/key_edge.sv
// key_edge: synchronises a raw active-low key into the clk domain and emits a
// one-cycle registered press pulse on its 1-to-0 transition.
// Pin-to-pulse latency is three clock cycles (two synchroniser flops, then the
// registered edge detector).
// Ports:
//   clk    - clock
//   rst    - asynchronous active-low reset (synchroniser flops reset to 1,
//            i.e. key released)
//   key_n  - raw active-low key, asynchronous to clk
//   press  - one-cycle pulse per key press
module key_edge (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic press_q;
    logic press_d;

    // Falling edge of the synchronised level: released last cycle, pressed now.
    always_comb begin
        press_d = prev_q & ~sync2_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: top-level game flow controller.
// Tracks the game state (IDLE/PLAY/HIT/OVER/PAUSE), score and lives, evaluates
// bullet/object hits and object misses once per frame, and issues one-cycle
// respawn / bullet-clear commands. All outputs are registered.
//
// Optional feature: define GAME_SEQUENCER_PAUSE_EN to add the key_pause_n
// input and the PAUSE state. Without it the port is absent and PAUSE is never
// entered.
//
// Ports:
//   clk            - 25 MHz pixel clock
//   rst            - asynchronous active-low reset
//   frame_tick     - one-cycle pulse per frame (vertical blank start)
//   key_start_n    - raw active-low start key
//   key_pause_n    - raw active-low pause key (GAME_SEQUENCER_PAUSE_EN only)
//   bullet_active  - bullet in flight
//   bullet_x/y     - bullet position
//   object_x/y     - object top-left position
//   run            - enable for object, bullet and controls logic
//   object_respawn - one-cycle respawn command
//   bullet_clear   - one-cycle bullet clear command
//   score          - saturating score
//   lives          - remaining lives
//   state          - current state encoding
//   game_over      - high in OVER
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned SCORE_W    = 8,
    parameter int unsigned LIVES_INIT = 3,
    parameter int unsigned HIT_FRAMES = 30,
    parameter int unsigned OBJ_W      = OBJ_W_DEF,
    parameter int unsigned OBJ_H      = OBJ_H_DEF,
    parameter int unsigned GROUND_Y   = GROUND_Y_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               key_start_n,
`ifdef GAME_SEQUENCER_PAUSE_EN
    input  logic               key_pause_n,
`endif
    input  logic               bullet_active,
    input  logic [9:0]         bullet_x,
    input  logic [8:0]         bullet_y,
    input  logic [10:0]        object_x,
    input  logic [8:0]         object_y,
    output logic               run,
    output logic               object_respawn,
    output logic               bullet_clear,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         lives,
    output logic [2:0]         state,
    output logic               game_over
);

    localparam logic [1:0]  LIVES_LOAD = 2'(LIVES_INIT);
    localparam logic [5:0]  HIT_LAST   = 6'(HIT_FRAMES - 1);
    localparam logic [11:0] OBJ_W_12   = 12'(OBJ_W);
    localparam logic [11:0] OBJ_H_12   = 12'(OBJ_H);
    localparam logic [11:0] GROUND_12  = 12'(GROUND_Y);

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // ---------------------------------------------------------------------
    // Key synchronisation and press detection
    // ---------------------------------------------------------------------
    logic start_press;
    logic pause_press;

    key_edge u_start_key (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_start_n),
        .press (start_press)
    );

`ifdef GAME_SEQUENCER_PAUSE_EN
    key_edge u_pause_key (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_pause_n),
        .press (pause_press)
    );
`else
    assign pause_press = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // Hit / miss geometry. Everything is widened to 12 bits so that the
    // right/bottom box edges (position + size) cannot wrap.
    // ---------------------------------------------------------------------
    logic [11:0] bx_w, by_w, ox_w, oy_w, ox_end, oy_end;
    logic        hit, miss;

    always_comb begin
        bx_w   = {2'b00, bullet_x};
        by_w   = {3'b000, bullet_y};
        ox_w   = {1'b0, object_x};
        oy_w   = {3'b000, object_y};
        ox_end = ox_w + OBJ_W_12;
        oy_end = oy_w + OBJ_H_12;
        hit    = bullet_active
                 && (bx_w >= ox_w) && (bx_w < ox_end)
                 && (by_w >= oy_w) && (by_w < oy_end);
        miss   = (oy_w >= GROUND_12);
    end

    // ---------------------------------------------------------------------
    // Sequencer next-state logic
    // ---------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [1:0]         lives_q, lives_d;
    logic [5:0]         cnt_q, cnt_d;
    logic               run_q, run_d;
    logic               respawn_q, respawn_d;
    logic               bclr_q, bclr_d;
    logic               over_q, over_d;
`ifdef GAME_SEQUENCER_PAUSE_EN
    state_t             ret_q, ret_d;  // state to resume when leaving PAUSE
`endif

    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        lives_d   = lives_q;
        cnt_d     = cnt_q;
        respawn_d = 1'b0;
        bclr_d    = 1'b0;
`ifdef GAME_SEQUENCER_PAUSE_EN
        ret_d     = ret_q;
`endif

        unique case (state_q)
            IDLE, OVER: begin
                if (start_press) begin
                    state_d   = PLAY;
                    score_d   = '0;
                    lives_d   = LIVES_LOAD;
                    cnt_d     = '0;
                    respawn_d = 1'b1;
                    bclr_d    = 1'b1;
                end
            end
            PLAY: begin
                if (pause_press) begin
                    state_d = PAUSE;
`ifdef GAME_SEQUENCER_PAUSE_EN
                    ret_d   = PLAY;
`endif
                end else if (frame_tick) begin
                    // A hit takes priority; a simultaneous miss is dropped.
                    if (hit) begin
                        state_d   = HIT;
                        score_d   = sat_inc(score_q);
                        cnt_d     = '0;
                        respawn_d = 1'b1;
                        bclr_d    = 1'b1;
                    end else if (miss) begin
                        respawn_d = 1'b1;
                        lives_d   = lives_q - 2'd1;
                        if (lives_q == 2'd1) begin
                            state_d = OVER;
                        end
                    end
                end
            end
            HIT: begin
                if (pause_press) begin
                    state_d = PAUSE;
`ifdef GAME_SEQUENCER_PAUSE_EN
                    ret_d   = HIT;
`endif
                end else if (frame_tick) begin
                    if (cnt_q == HIT_LAST) begin
                        state_d = PLAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            PAUSE: begin
`ifdef GAME_SEQUENCER_PAUSE_EN
                // Frame ticks are ignored here, so the HIT counter is frozen.
                if (pause_press) begin
                    state_d = ret_q;
                end
`else
                state_d = IDLE;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        run_d  = (state_d == PLAY) || (state_d == HIT);
        over_d = (state_d == OVER);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            score_q   <= '0;
            lives_q   <= LIVES_LOAD;
            cnt_q     <= '0;
            run_q     <= 1'b0;
            respawn_q <= 1'b0;
            bclr_q    <= 1'b0;
            over_q    <= 1'b0;
`ifdef GAME_SEQUENCER_PAUSE_EN
            ret_q     <= PLAY;
`endif
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            lives_q   <= lives_d;
            cnt_q     <= cnt_d;
            run_q     <= run_d;
            respawn_q <= respawn_d;
            bclr_q    <= bclr_d;
            over_q    <= over_d;
`ifdef GAME_SEQUENCER_PAUSE_EN
            ret_q     <= ret_d;
`endif
        end
    end

    assign state          = state_q;
    assign score          = score_q;
    assign lives          = lives_q;
    assign run            = run_q;
    assign object_respawn = respawn_q;
    assign bullet_clear   = bclr_q;
    assign game_over      = over_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed, table-driven bench for game_sequencer with
// default parameters. Pause coverage is compiled in when
// GAME_SEQUENCER_PAUSE_EN is defined.
module tb_game_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic        key_start_n;
`ifdef GAME_SEQUENCER_PAUSE_EN
    logic        key_pause_n;
`endif
    logic        bullet_active;
    logic [9:0]  bullet_x;
    logic [8:0]  bullet_y;
    logic [10:0] object_x;
    logic [8:0]  object_y;
    logic        run;
    logic        object_respawn;
    logic        bullet_clear;
    logic [7:0]  score;
    logic [1:0]  lives;
    logic [2:0]  state;
    logic        game_over;

    int checks = 0;
    int failures = 0;

    always #20 clk = ~clk;

    game_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .frame_tick     (frame_tick),
        .key_start_n    (key_start_n),
`ifdef GAME_SEQUENCER_PAUSE_EN
        .key_pause_n    (key_pause_n),
`endif
        .bullet_active  (bullet_active),
        .bullet_x       (bullet_x),
        .bullet_y       (bullet_y),
        .object_x       (object_x),
        .object_y       (object_y),
        .run            (run),
        .object_respawn (object_respawn),
        .bullet_clear   (bullet_clear),
        .score          (score),
        .lives          (lives),
        .state          (state),
        .game_over      (game_over)
    );

    typedef struct {
        logic        ft;
        logic        ba;
        logic [9:0]  bx;
        logic [8:0]  by;
        logic [10:0] ox;
        logic [8:0]  oy;
        logic [2:0]  st;
        logic [7:0]  sc;
        logic [1:0]  lv;
        logic        rsp;
        logic        bcl;
        logic        rn;
        logic        ovr;
        logic        ex;   // row enters HIT: run the 30-tick exit afterwards
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input int ft, input int ba, input int bx, input int by,
                                input int ox, input int oy, input int st, input int sc,
                                input int lv, input int rsp, input int bcl, input int rn,
                                input int ovr, input int ex);
        vec_t v;
        v.ft = ft[0];   v.ba = ba[0];
        v.bx = bx[9:0]; v.by = by[8:0]; v.ox = ox[10:0]; v.oy = oy[8:0];
        v.st = st[2:0]; v.sc = sc[7:0]; v.lv = lv[1:0];
        v.rsp = rsp[0]; v.bcl = bcl[0]; v.rn = rn[0]; v.ovr = ovr[0]; v.ex = ex[0];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [2:0] st, input logic [7:0] sc,
                              input logic [1:0] lv, input logic rsp, input logic bcl,
                              input logic rn, input logic ovr);
        check({tag, ".state"},   32'(state), 32'(st));
        check({tag, ".score"},   32'(score), 32'(sc));
        check({tag, ".lives"},   32'(lives), 32'(lv));
        check({tag, ".respawn"}, 32'(object_respawn), 32'(rsp));
        check({tag, ".bclear"},  32'(bullet_clear), 32'(bcl));
        check({tag, ".run"},     32'(run), 32'(rn));
        check({tag, ".over"},    32'(game_over), 32'(ovr));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
    endtask

    // Hold the start key low for 5 cycles and watch 12 cycles.
    task automatic press_start(output int first_play, output int rsp_cnt, output int bcl_cnt);
        first_play = -1;
        rsp_cnt = 0;
        bcl_cnt = 0;
        key_start_n = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            cyc();
            if (c == 5) key_start_n = 1'b1;
            if (state == 3'b001 && first_play < 0) first_play = c;
            rsp_cnt += int'(object_respawn);
            bcl_cnt += int'(bullet_clear);
        end
    endtask

    // From HIT: 29 ticks stay in HIT, the 30th returns to PLAY.
    task automatic hit_exit(input string tag);
        bullet_active = 1'b0;
        for (int i = 1; i <= 29; i++) do_tick();
        check({tag, ".hit_after29"}, 32'(state), 32'd2);
        check({tag, ".respawn_in_hit"}, 32'(object_respawn), 32'd0);
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        check({tag, ".play_after30"}, 32'(state), 32'd1);
    endtask

    task automatic do_hit();
        bullet_active = 1'b1;
        bullet_x = 10'd100; bullet_y = 9'd200;
        object_x = 11'd90;  object_y = 9'd190;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        bullet_active = 1'b0;
    endtask

    initial begin
        int fp, rc, bc;

        rst = 1'b0;
        frame_tick = 1'b0;
        key_start_n = 1'b1;
`ifdef GAME_SEQUENCER_PAUSE_EN
        key_pause_n = 1'b1;
`endif
        bullet_active = 1'b0;
        bullet_x = '0; bullet_y = '0;
        object_x = 11'd90; object_y = 9'd190;

        // PLAY: {ft,ba,bx,by,ox,oy} -> {state,score,lives,rsp,bcl,run,over,exit}
        vecs[0]  = mk(0,1,100,200, 90,190, 1,0,3, 0,0,1,0, 0);
        vecs[1]  = mk(1,0,100,200, 90,190, 1,0,3, 0,0,1,0, 0);
        vecs[2]  = mk(1,1,100,200, 90,190, 2,1,3, 1,1,1,0, 1);
        vecs[3]  = mk(1,1,122,200, 90,190, 1,1,3, 0,0,1,0, 0);
        vecs[4]  = mk(1,1, 89,200, 90,190, 1,1,3, 0,0,1,0, 0);
        vecs[5]  = mk(1,1,100,222, 90,190, 1,1,3, 0,0,1,0, 0);
        vecs[6]  = mk(1,1,121,221, 90,190, 2,2,3, 1,1,1,0, 1);
        vecs[7]  = mk(1,0,100,200, 90,447, 1,2,3, 0,0,1,0, 0);
        vecs[8]  = mk(1,1,100,460, 90,448, 2,3,3, 1,1,1,0, 1);
        vecs[9]  = mk(1,1,100,500, 90,490, 2,4,3, 1,1,1,0, 1);
        vecs[10] = mk(1,0,100,200, 90,448, 1,4,2, 1,0,1,0, 0);
        vecs[11] = mk(0,0,100,200, 90,448, 1,4,2, 0,0,1,0, 0);
        vecs[12] = mk(1,0,100,200, 90,448, 1,4,1, 1,0,1,0, 0);
        vecs[13] = mk(0,0,100,200, 90,448, 1,4,1, 0,0,1,0, 0);
        vecs[14] = mk(1,0,100,200, 90,448, 3,4,0, 1,0,0,1, 0);
        vecs[15] = mk(1,1,100,200, 90,190, 3,4,0, 0,0,0,1, 0);

        // Reset values
        cyc();
        cyc();
        check_outs("reset", 3'd0, 8'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        cyc();
        check("idle_after_release", 32'(state), 32'd0);

        // Start from IDLE
        press_start(fp, rc, bc);
        check("start.first_play_cycle", 32'(fp), 32'd4);
        check("start.respawn_pulses", 32'(rc), 32'd1);
        check("start.bclear_pulses", 32'(bc), 32'd1);
        check_outs("start", 3'd1, 8'd0, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0);

        // Table-driven frame events
        for (int i = 0; i < 16; i++) begin
            frame_tick    = vecs[i].ft;
            bullet_active = vecs[i].ba;
            bullet_x      = vecs[i].bx;
            bullet_y      = vecs[i].by;
            object_x      = vecs[i].ox;
            object_y      = vecs[i].oy;
            cyc();
            frame_tick = 1'b0;
            check_outs($sformatf("vec%0d", i), vecs[i].st, vecs[i].sc, vecs[i].lv,
                       vecs[i].rsp, vecs[i].bcl, vecs[i].rn, vecs[i].ovr);
            if (vecs[i].ex) begin
                cyc();
                check($sformatf("vec%0d.single_respawn", i), 32'(object_respawn), 32'd0);
                check($sformatf("vec%0d.single_bclear", i), 32'(bullet_clear), 32'd0);
                hit_exit($sformatf("vec%0d", i));
            end
        end

        // Restart from OVER
        object_y = 9'd190;
        press_start(fp, rc, bc);
        check("restart.first_play_cycle", 32'(fp), 32'd4);
        check("restart.respawn_pulses", 32'(rc), 32'd1);
        check_outs("restart", 3'd1, 8'd0, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0);

        // Start ignored in PLAY
        press_start(fp, rc, bc);
        check("play_start_ignored.respawn", 32'(rc), 32'd0);
        check("play_start_ignored.state", 32'(state), 32'd1);

        // Score saturation: 255 hits reach 255, one more stays at 255
        for (int h = 0; h < 255; h++) begin
            do_hit();
            hit_exit("sat");
        end
        check("sat.score255", 32'(score), 32'd255);
        do_hit();
        check("sat.score_held", 32'(score), 32'd255);
        check("sat.state_hit", 32'(state), 32'd2);
        check("sat.respawn", 32'(object_respawn), 32'd1);

        // Start ignored in HIT
        press_start(fp, rc, bc);
        check("hit_start_ignored.state", 32'(state), 32'd2);
        check("hit_start_ignored.respawn", 32'(rc), 32'd0);

        // Asynchronous reset mid-HIT
        for (int i = 0; i < 5; i++) do_tick();
        @(posedge clk);
        #5;
        rst = 1'b0;
        #1;
        check_outs("async_reset", 3'd0, 8'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        rst = 1'b1;
        cyc();
        cyc();
        check_outs("after_reset", 3'd0, 8'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef GAME_SEQUENCER_PAUSE_EN
        begin
            int waited;
            press_start(fp, rc, bc);
            check("pause.start", 32'(state), 32'd1);
            do_hit();
            check("pause.hit", 32'(state), 32'd2);
            for (int i = 0; i < 10; i++) do_tick();
            key_pause_n = 1'b0;
            waited = 0;
            while (state != 3'd4 && waited < 12) begin
                cyc();
                waited++;
                if (waited == 5) key_pause_n = 1'b1;
            end
            key_pause_n = 1'b1;
            check("pause.entered", 32'(state), 32'd4);
            check("pause.run_low", 32'(run), 32'd0);
            for (int i = 0; i < 8; i++) cyc();
            for (int i = 0; i < 50; i++) do_tick();
            check("pause.frozen", 32'(state), 32'd4);
            key_pause_n = 1'b0;
            waited = 0;
            while (state != 3'd2 && waited < 12) begin
                cyc();
                waited++;
                if (waited == 5) key_pause_n = 1'b1;
            end
            key_pause_n = 1'b1;
            check("pause.resumed_hit", 32'(state), 32'd2);
            check("pause.run_high", 32'(run), 32'd1);
            for (int i = 0; i < 8; i++) cyc();
            for (int i = 0; i < 19; i++) do_tick();
            check("pause.hit_after19", 32'(state), 32'd2);
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
            check("pause.play_after20", 32'(state), 32'd1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter SCORE_W, default 8, score counter width in bits.
REQ-002 SHALL have parameter LIVES_INIT, default 3, lives loaded at reset and at game start (range 1..3).
REQ-003 SHALL have parameter HIT_FRAMES, default 30, frames spent in HIT before returning to PLAY (range 1..63).
REQ-004 SHALL have parameters OBJ_W, default 32, and OBJ_H, default 32, object bounding box in pixels.
REQ-005 SHALL have parameter GROUND_Y, default 448, object Y at or beyond which the object counts as missed.
REQ-006 SHALL have ports clk, in, 1, 25 MHz pixel clock; rst, in, 1, asynchronous active-low reset.
REQ-007 SHALL have port frame_tick, in, 1, one-cycle pulse per frame at vertical blank start.
REQ-008 SHALL have port key_start_n, in, 1, raw active-low start key, asynchronous to clk.
REQ-009 SHALL have ports bullet_active, in, 1; bullet_x, in, 10; bullet_y, in, 9: bullet state.
REQ-010 SHALL have ports object_x, in, 11; object_y, in, 9: object top-left position.
REQ-011 SHALL have port run, out, 1, enable for object, bullet and controls logic.
REQ-012 SHALL have ports object_respawn, out, 1, and bullet_clear, out, 1: one-cycle command pulses.
REQ-013 SHALL have ports score, out, SCORE_W; lives, out, 2; state, out, 3; game_over, out, 1.

Function
REQ-014 SHALL encode states as IDLE=000, PLAY=001, HIT=010, OVER=011, PAUSE=100.
REQ-015 SHALL synchronise each key with two flops and detect press on the 1-to-0 edge, giving 3-cycle latency from pin to press pulse.
REQ-016 SHALL, in IDLE or OVER on a start press, go to PLAY next cycle, clear score, load lives=LIVES_INIT, and pulse object_respawn and bullet_clear.
REQ-017 SHALL evaluate events only in PLAY on frame_tick cycles: hit = bullet_active and object_x <= bullet_x < object_x+OBJ_W and object_y <= bullet_y < object_y+OBJ_H; miss = object_y >= GROUND_Y.
REQ-018 SHALL perform the hit comparisons at 12-bit width zero-extended so that object_x+OBJ_W cannot wrap.
REQ-019 SHALL, on a hit at cycle T, at T+1 enter HIT, increment score saturating at 2^SCORE_W-1, and pulse object_respawn and bullet_clear for exactly one cycle.
REQ-020 SHALL, on a miss without a hit, at T+1 decrement lives and pulse object_respawn; if lives was 1, lives becomes 0 and the state goes to OVER instead.
REQ-021 SHALL give hit priority when hit and miss occur on the same frame_tick: the miss is discarded.
REQ-022 SHALL, in HIT, count frame_tick pulses from 0 and return to PLAY on the cycle after the HIT_FRAMES-th tick, clearing the counter.
REQ-023 SHALL drive run=1 only in PLAY and HIT, and game_over=1 only in OVER.
REQ-024 SHALL ignore start presses in PLAY, HIT and PAUSE.
REQ-025 SHALL register all outputs, with state equal to the current state register.

Reset
REQ-026 SHALL, while rst=0, asynchronously force: state=IDLE, score=0, lives=LIVES_INIT, run=0, object_respawn=0, bullet_clear=0, game_over=0, frame counter=0, key synchronisers=1.
REQ-027 SHALL, on reset assertion during any state, abandon the game and drop all pending pulses, restarting in IDLE when rst is released.

Configuration
REQ-028 SHALL, when GAME_SEQUENCER_PAUSE_EN is defined, add input key_pause_n (1 bit, raw, active-low), synchronised per REQ-015.
REQ-029 SHALL, with the macro defined, on a pause press toggle between PLAY or HIT and PAUSE, with run=0 in PAUSE; frame_tick and the frame counter are frozen in PAUSE, and HIT is resumed with its counter value kept.
REQ-030 SHALL, without GAME_SEQUENCER_PAUSE_EN, omit port key_pause_n and make PAUSE unreachable.

Structure
REQ-031 SHALL take state encodings and OBJ_W/OBJ_H/GROUND_Y defaults from shared package game_pkg.
REQ-032 SHALL implement the synchroniser and edge detection as sub-module key_edge, instantiated once per key.

Verification
REQ-033 SHALL cover: reset, then key_start_n low for 5 cycles -> state=001, lives=3, score=0, one object_respawn pulse.
REQ-034 SHALL cover: PLAY, bullet (100,200), object (90,190), frame_tick -> next cycle state=010, score=1, single pulses; 30 ticks later state=001.
REQ-035 SHALL cover: object_y=448 with no hit on three successive ticks -> lives 2,1,0, then state=011 and game_over=1.
REQ-036 SHALL cover: hit and object_y=448 on the same tick -> score+1 and lives unchanged.
REQ-037 SHALL cover: score at 255 plus a hit -> score stays 255; rst low mid-HIT -> all outputs at reset values immediately.
REQ-038 SHALL cover, with GAME_SEQUENCER_PAUSE_EN: a pause press in HIT after 10 ticks, then 50 ticks, then a second press -> HIT resumes and exits after 20 more ticks.
